ex_operand_issue: RTL and testbench
===================================

// Module: ex_operand_issue
// PURPOSE
//  ID->EX issue stage. Registers the decoded instruction and drives the ALU and comparator operand inputs of EX.
//  Applies EX/MEM and MEM/WB forwarding, detects load-use hazards, and inserts bubbles.
//  Obeys flush from branch resolution and hold from downstream memory stalls.
// PARAMETERS
//  XLEN    32  datapath width
//  REG_AW  5   register index width
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       synchronous active-low reset
//  id_valid      in   1       ID holds a real instruction
//  id_rs1/id_rs2 in   REG_AW  source register indices
//  id_rs1_data   in   XLEN    regfile read data, rs1
//  id_rs2_data   in   XLEN    regfile read data, rs2
//  id_imm        in   XLEN    sign-extended immediate
//  id_pc         in   XLEN    instruction PC
//  id_asel       in   1       0:A=rs1 1:A=pc
//  id_bsel       in   1       0:B=rs2 1:B=imm
//  id_aluop      in   3       ALU op, encoding from param.v
//  id_unsigned   in   1       unsigned compare/op
//  id_rd         in   REG_AW  destination register
//  id_regwrite   in   1       instruction writes rd
//  id_memread    in   1       instruction is a load
//  mem_rd, mem_regwrite, mem_data      in  REG_AW/1/XLEN  EX/MEM producer
//  wb_rd,  wb_regwrite,  wb_data       in  REG_AW/1/XLEN  MEM/WB producer
//  flush         in   1       kill the issued slot (branch taken)
//  hold          in   1       downstream stall; freeze everything
//  stall_id      out  1       ID/IF must hold their instruction this cycle
//  Ain, Bin, COMPAin, COMPBin   out  XLEN  EX operands
//  ALUop         out  3       to EX
//  Unsigned      out  1       to EX
//  ex_valid, ex_rd, ex_regwrite, ex_memread   out  1/REG_AW/1/1  passed down the pipe
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all registered fields 0, so ex_valid=0 and ALUop=0.
//    All outputs 0, stall_id=0. An in-flight instruction is discarded.
//  - Latency 1: ID fields captured at posedge N appear at the EX outputs after that edge.
//  - Load-use (comb.): stall_id=1 when ex_valid & ex_memread & ex_rd!=0 & id_valid
//    & (ex_rd==id_rs1 | ex_rd==id_rs2).
//    The next edge captures a bubble: ex_valid=0, ex_regwrite=0, ex_memread=0. ID holds.
//  - Update priority at the edge: rst_n=0 > flush (bubble) > hold (all regs keep value) > load-use (bubble) > capture ID.
//  - stall_id is forced 1 while hold=1. Flush+hold in the same cycle: flush wins and a bubble is written.
//  - Forwarding (comb., on registered rs1/rs2 and data):
//    - Use mem_data if mem_regwrite & mem_rd!=0 & mem_rd==rs.
//    - Else use wb_data if wb_regwrite & wb_rd!=0 & wb_rd==rs.
//    - Else use the registered regfile data.
//    - Index 0 is never forwarded and reads as 0 regardless of latched data.
//  - Operand select:
//    - COMPAin=fwd_rs1, COMPBin=fwd_rs2.
//    - Ain = asel ? pc : fwd_rs1.
//    - Bin = bsel ? imm : fwd_rs2.
//  - Bubble slot: operands may be any value, but ex_regwrite=0 and ex_memread=0.
//  - Registers hold no arithmetic state; widths pass through unchanged, no truncation.
// STRUCTURE
//  - param.v holds the ALUop encodings, ASEL/BSEL codes, XLEN, REG_AW, and the NOP/bubble field values.
//  - One sub-module, fwd_select: given rs, regfile data and both producers, it returns the forwarded value.
//    Instantiate it twice (rs1, rs2).
//  - The pipeline register and hazard logic stay in this module.
// TESTING
//  1. Reset/capture: rst_n=0 for 2 cycles -> all outputs 0.
//     Release; issue ADD x3,x1,x2 with data 5,7 -> next cycle Ain=5, Bin=7, ex_rd=3, ex_valid=1.
//  2. Forwarding priority: issued rs1=4; mem_rd=4 data=0x11; wb_rd=4 data=0x22 -> Ain=0x11.
//     Drop mem_regwrite -> Ain=0x22. Set rs1=0 with mem_rd=0 -> Ain=0.
//  3. Load-use: issued LW x5; ID ADD x6,x5,x1 -> stall_id=1 for exactly 1 cycle.
//     The following slot has ex_valid=0, ex_regwrite=0. The ADD issues on the next edge with wb forwarding of x5.
//  4. Flush: flush=1 with valid ID -> next cycle ex_valid=0, ex_regwrite=0.
//     Flush+hold together -> bubble still written.
//  5. Hold: hold=1 for 3 cycles -> all EX outputs stable, stall_id=1.
//     Release -> pending ID instruction captured once, not duplicated.
//  6. Operand select: asel=1, bsel=1, pc=0x100, imm=-4 -> Ain=0x100, Bin=0xFFFFFFFC.
//     COMPAin/COMPBin still equal the forwarded rs1/rs2.

Source files
------------

// File: rtl/ex_operand_issue_pkg.sv
// Shared types and constants for the ID->EX operand issue stage.
package ex_operand_issue_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  // ALU operation encodings carried through to EX.
  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluSll = 3'd5,
    AluSrl = 3'd6,
    AluSra = 3'd7
  } alu_op_e;

  // Operand select codes.
  localparam logic ASEL_RS1 = 1'b0;
  localparam logic ASEL_PC  = 1'b1;
  localparam logic BSEL_RS2 = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

  localparam logic [2:0] ALUOP_NOP = 3'd0;

  // One issued instruction as held in the ID/EX pipeline register.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic              asel;
    logic              bsel;
    logic [2:0]        aluop;
    logic              is_unsigned;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } issue_slot_t;

  // Bubble and reset value: nothing valid, nothing written, ALU op is NOP.
  localparam issue_slot_t BUBBLE_SLOT = '0;

  // A load sitting in EX whose destination is read by the instruction in ID.
  function automatic logic is_load_use(input issue_slot_t       ex,
                                       input logic              id_valid,
                                       input logic [REG_AW-1:0] rs1,
                                       input logic [REG_AW-1:0] rs2);
    return ex.valid & ex.memread & (ex.rd != '0) & id_valid &
           ((ex.rd == rs1) | (ex.rd == rs2));
  endfunction

endpackage

// File: rtl/ex_operand_issue_if.sv
// Bundle of ID inputs, producer feedback, control and EX outputs of the issue stage.
interface ex_operand_issue_if;
  import ex_operand_issue_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [XLEN-1:0]   id_pc;
  logic              id_asel;
  logic              id_bsel;
  logic [2:0]        id_aluop;
  logic              id_unsigned;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;

  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic [XLEN-1:0]   mem_data;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic [XLEN-1:0]   wb_data;

  logic              flush;
  logic              hold;

  logic              stall_id;
  logic [XLEN-1:0]   Ain;
  logic [XLEN-1:0]   Bin;
  logic [XLEN-1:0]   COMPAin;
  logic [XLEN-1:0]   COMPBin;
  logic [2:0]        ALUop;
  logic              Unsigned;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;

  // Driver side: ID, producers and control.
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_asel, id_bsel, id_aluop, id_unsigned, id_rd, id_regwrite, id_memread,
           mem_rd, mem_regwrite, mem_data, wb_rd, wb_regwrite, wb_data, flush, hold,
    input  stall_id, Ain, Bin, COMPAin, COMPBin, ALUop, Unsigned,
           ex_valid, ex_rd, ex_regwrite, ex_memread
  );

  // Issue stage side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_pc,
           id_asel, id_bsel, id_aluop, id_unsigned, id_rd, id_regwrite, id_memread,
           mem_rd, mem_regwrite, mem_data, wb_rd, wb_regwrite, wb_data, flush, hold,
    output stall_id, Ain, Bin, COMPAin, COMPBin, ALUop, Unsigned,
           ex_valid, ex_rd, ex_regwrite, ex_memread
  );

endinterface

// File: rtl/ex_operand_issue_fwd_select.sv
// Forwarding mux for one source operand: EX/MEM beats MEM/WB beats regfile.
module ex_operand_issue_fwd_select
  import ex_operand_issue_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regwrite_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   fwd_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwrite_i & (mem_rd_i != '0) & (mem_rd_i == rs_i);
  assign wb_hit  = wb_regwrite_i & (wb_rd_i != '0) & (wb_rd_i == rs_i);

  // x0 reads as zero even if stale data was latched for it.
  always_comb begin
    fwd_o = rf_data_i;
    if (rs_i == '0) begin
      fwd_o = '0;
    end else if (mem_hit) begin
      fwd_o = mem_data_i;
    end else if (wb_hit) begin
      fwd_o = wb_data_i;
    end
  end

endmodule

// File: rtl/ex_operand_issue.sv
// ID->EX issue stage: pipeline register, load-use bubbles, flush/hold, operand forwarding.
module ex_operand_issue
  import ex_operand_issue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ex_operand_issue_if.slave bus
);

  issue_slot_t     slot_q;
  issue_slot_t     slot_d;
  issue_slot_t     id_slot;
  logic            load_use;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Gather the decoded ID fields into a candidate slot; an invalid ID never writes.
  always_comb begin
    id_slot             = BUBBLE_SLOT;
    id_slot.valid       = bus.id_valid;
    id_slot.rs1         = bus.id_rs1;
    id_slot.rs2         = bus.id_rs2;
    id_slot.rs1_data    = bus.id_rs1_data;
    id_slot.rs2_data    = bus.id_rs2_data;
    id_slot.imm         = bus.id_imm;
    id_slot.pc          = bus.id_pc;
    id_slot.asel        = bus.id_asel;
    id_slot.bsel        = bus.id_bsel;
    id_slot.aluop       = bus.id_aluop;
    id_slot.is_unsigned = bus.id_unsigned;
    id_slot.rd          = bus.id_rd;
    id_slot.regwrite    = bus.id_valid & bus.id_regwrite;
    id_slot.memread     = bus.id_valid & bus.id_memread;
  end

  assign load_use     = is_load_use(slot_q, bus.id_valid, bus.id_rs1, bus.id_rs2);
  assign bus.stall_id = bus.hold | load_use;

  // Next slot: flush beats hold, hold beats the load-use bubble, otherwise capture ID.
  always_comb begin
    slot_d = id_slot;
    if (bus.flush) begin
      slot_d = BUBBLE_SLOT;
    end else if (bus.hold) begin
      slot_d = slot_q;
    end else if (load_use) begin
      slot_d = BUBBLE_SLOT;
    end
  end

  // Pipeline register; reset discards whatever was in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= BUBBLE_SLOT;
    end else begin
      slot_q <= slot_d;
    end
  end

  ex_operand_issue_fwd_select u_fwd_select_rs1 (
    .rs_i           (slot_q.rs1),
    .rf_data_i      (slot_q.rs1_data),
    .mem_rd_i       (bus.mem_rd),
    .mem_regwrite_i (bus.mem_regwrite),
    .mem_data_i     (bus.mem_data),
    .wb_rd_i        (bus.wb_rd),
    .wb_regwrite_i  (bus.wb_regwrite),
    .wb_data_i      (bus.wb_data),
    .fwd_o          (fwd_rs1)
  );

  ex_operand_issue_fwd_select u_fwd_select_rs2 (
    .rs_i           (slot_q.rs2),
    .rf_data_i      (slot_q.rs2_data),
    .mem_rd_i       (bus.mem_rd),
    .mem_regwrite_i (bus.mem_regwrite),
    .mem_data_i     (bus.mem_data),
    .wb_rd_i        (bus.wb_rd),
    .wb_regwrite_i  (bus.wb_regwrite),
    .wb_data_i      (bus.wb_data),
    .fwd_o          (fwd_rs2)
  );

  assign bus.COMPAin     = fwd_rs1;
  assign bus.COMPBin     = fwd_rs2;
  assign bus.Ain         = (slot_q.asel == ASEL_PC) ? slot_q.pc : fwd_rs1;
  assign bus.Bin         = (slot_q.bsel == BSEL_IMM) ? slot_q.imm : fwd_rs2;
  assign bus.ALUop       = slot_q.aluop;
  assign bus.Unsigned    = slot_q.is_unsigned;
  assign bus.ex_valid    = slot_q.valid;
  assign bus.ex_rd       = slot_q.rd;
  assign bus.ex_regwrite = slot_q.regwrite;
  assign bus.ex_memread  = slot_q.memread;

endmodule

// File: tb/tb_ex_operand_issue.sv
// Directed plus random checks of ex_operand_issue against a slot-level reference model.
module tb_ex_operand_issue;
  import ex_operand_issue_pkg::*;

  // What the stage should currently be presenting to EX.
  typedef struct {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   d1;
    logic [XLEN-1:0]   d2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic              asel;
    logic              bsel;
    logic              uns;
    logic              rw;
    logic              mr;
    logic [2:0]        op;
  } slot_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    n_assert = 0;
  int    n_fail = 0;
  slot_t m;

  ex_operand_issue_if bus ();

  ex_operand_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_fwd(input logic [REG_AW-1:0] rs,
                                              input logic [XLEN-1:0] rf);
    if (rs == '0) return '0;
    if (bus.mem_regwrite && bus.mem_rd == rs) return bus.mem_data;
    if (bus.wb_regwrite && bus.wb_rd == rs) return bus.wb_data;
    return rf;
  endfunction

  function automatic logic ref_stall();
    return bus.hold || (m.valid && m.mr && m.rd != '0 && bus.id_valid &&
                        (m.rd == bus.id_rs1 || m.rd == bus.id_rs2));
  endfunction

  task automatic check_model(input string tag);
    logic [XLEN-1:0] f1;
    logic [XLEN-1:0] f2;
    chk({tag, ".stall"}, 32'(bus.stall_id), 32'(ref_stall()));
    chk({tag, ".valid"}, 32'(bus.ex_valid), 32'(m.valid));
    chk({tag, ".rw"}, 32'(bus.ex_regwrite), 32'(m.rw));
    chk({tag, ".mr"}, 32'(bus.ex_memread), 32'(m.mr));
    if (m.valid) begin
      f1 = ref_fwd(m.rs1, m.d1);
      f2 = ref_fwd(m.rs2, m.d2);
      chk({tag, ".Ain"}, bus.Ain, m.asel ? m.pc : f1);
      chk({tag, ".Bin"}, bus.Bin, m.bsel ? m.imm : f2);
      chk({tag, ".CA"}, bus.COMPAin, f1);
      chk({tag, ".CB"}, bus.COMPBin, f2);
      chk({tag, ".op"}, 32'(bus.ALUop), 32'(m.op));
      chk({tag, ".uns"}, 32'(bus.Unsigned), 32'(m.uns));
      chk({tag, ".rd"}, 32'(bus.ex_rd), 32'(m.rd));
    end
  endtask

  // Advance one clock, applying the update priority to the model.
  task automatic tick();
    slot_t nx;
    nx = m;
    if (!rst_n) begin
      nx = '{default: '0};
    end else if (bus.flush) begin
      nx.valid = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0;
    end else if (bus.hold) begin
      nx = m;
    end else if (ref_stall()) begin
      nx.valid = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0;
    end else begin
      nx.valid = bus.id_valid;
      nx.rs1 = bus.id_rs1;        nx.rs2 = bus.id_rs2;     nx.rd = bus.id_rd;
      nx.d1 = bus.id_rs1_data;    nx.d2 = bus.id_rs2_data;
      nx.imm = bus.id_imm;        nx.pc = bus.id_pc;
      nx.asel = bus.id_asel;      nx.bsel = bus.id_bsel;
      nx.uns = bus.id_unsigned;   nx.op = bus.id_aluop;
      nx.rw = bus.id_valid & bus.id_regwrite;
      nx.mr = bus.id_valid & bus.id_memread;
    end
    @(posedge clk);
    #1;
    m = nx;
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0; bus.id_pc = '0;
    bus.id_asel = 1'b0; bus.id_bsel = 1'b0; bus.id_aluop = '0; bus.id_unsigned = 1'b0;
    bus.id_rd = '0; bus.id_regwrite = 1'b0; bus.id_memread = 1'b0;
    bus.mem_rd = '0; bus.mem_regwrite = 1'b0; bus.mem_data = '0;
    bus.wb_rd = '0; bus.wb_regwrite = 1'b0; bus.wb_data = '0;
    bus.flush = 1'b0; bus.hold = 1'b0;
  endtask

  task automatic set_id(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                        input logic [REG_AW-1:0] rd, input logic rw, input logic mr);
    bus.id_valid = 1'b1; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_rd = rd;
    bus.id_regwrite = rw; bus.id_memread = mr;
    bus.id_asel = ASEL_RS1; bus.id_bsel = BSEL_RS2; bus.id_imm = '0; bus.id_pc = '0;
    bus.id_aluop = AluAdd; bus.id_unsigned = 1'b0;
  endtask

  initial begin
    m = '{default: '0};
    idle();

    // Reset for two cycles, everything must read zero.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst.Ain", bus.Ain, 32'h0);
    chk("rst.Bin", bus.Bin, 32'h0);
    chk("rst.CA", bus.COMPAin, 32'h0);
    chk("rst.CB", bus.COMPBin, 32'h0);
    chk("rst.op", 32'(bus.ALUop), 32'h0);
    chk("rst.uns", 32'(bus.Unsigned), 32'h0);
    chk("rst.valid", 32'(bus.ex_valid), 32'h0);
    chk("rst.rd", 32'(bus.ex_rd), 32'h0);
    chk("rst.rw", 32'(bus.ex_regwrite), 32'h0);
    chk("rst.mr", 32'(bus.ex_memread), 32'h0);
    chk("rst.stall", 32'(bus.stall_id), 32'h0);

    // ADD x3,x1,x2 with data 5,7.
    rst_n = 1'b1;
    set_id(5'd1, 5'd2, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    #1;
    check_model("add.pre");
    tick();
    chk("add.Ain", bus.Ain, 32'd5);
    chk("add.Bin", bus.Bin, 32'd7);
    chk("add.rd", 32'(bus.ex_rd), 32'd3);
    chk("add.valid", 32'(bus.ex_valid), 32'd1);
    check_model("add");

    // Forwarding priority on rs1=4.
    set_id(5'd4, 5'd0, 32'h99, 32'h0, 5'd8, 1'b1, 1'b0);
    tick();
    idle();
    bus.mem_rd = 5'd4; bus.mem_regwrite = 1'b1; bus.mem_data = 32'h11;
    bus.wb_rd = 5'd4;  bus.wb_regwrite = 1'b1;  bus.wb_data = 32'h22;
    #1;
    chk("fwd.mem", bus.Ain, 32'h11);
    check_model("fwd.mem");
    bus.mem_regwrite = 1'b0;
    #1;
    chk("fwd.wb", bus.Ain, 32'h22);
    check_model("fwd.wb");
    set_id(5'd0, 5'd0, 32'h55, 32'h66, 5'd9, 1'b1, 1'b0);
    bus.mem_rd = 5'd0; bus.mem_regwrite = 1'b1; bus.mem_data = 32'h33;
    bus.wb_rd = 5'd0;  bus.wb_regwrite = 1'b1;  bus.wb_data = 32'h44;
    tick();
    chk("fwd.x0", bus.Ain, 32'h0);
    chk("fwd.x0b", bus.COMPBin, 32'h0);
    check_model("fwd.x0");

    // Load-use: LW x5 then ADD x6,x5,x1.
    idle();
    set_id(5'd1, 5'd0, 32'h40, 32'h0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(5'd5, 5'd1, 32'hDEAD, 32'h3, 5'd6, 1'b1, 1'b0);
    #1;
    chk("lu.stall1", 32'(bus.stall_id), 32'd1);
    check_model("lu.pre");
    tick();
    chk("lu.bub.valid", 32'(bus.ex_valid), 32'd0);
    chk("lu.bub.rw", 32'(bus.ex_regwrite), 32'd0);
    chk("lu.bub.mr", 32'(bus.ex_memread), 32'd0);
    chk("lu.stall0", 32'(bus.stall_id), 32'd0);
    tick();
    bus.wb_rd = 5'd5; bus.wb_regwrite = 1'b1; bus.wb_data = 32'hABCD;
    #1;
    chk("lu.wbfwd", bus.Ain, 32'hABCD);
    chk("lu.rd", 32'(bus.ex_rd), 32'd6);
    chk("lu.valid", 32'(bus.ex_valid), 32'd1);
    check_model("lu.issue");

    // Flush, then flush together with hold.
    idle();
    set_id(5'd1, 5'd2, 32'h1, 32'h2, 5'd7, 1'b1, 1'b0);
    bus.flush = 1'b1;
    tick();
    chk("fl.valid", 32'(bus.ex_valid), 32'd0);
    chk("fl.rw", 32'(bus.ex_regwrite), 32'd0);
    bus.flush = 1'b0;
    tick();
    chk("fl.refill", 32'(bus.ex_valid), 32'd1);
    bus.flush = 1'b1; bus.hold = 1'b1;
    #1;
    chk("flh.stall", 32'(bus.stall_id), 32'd1);
    tick();
    chk("flh.valid", 32'(bus.ex_valid), 32'd0);
    chk("flh.rw", 32'(bus.ex_regwrite), 32'd0);
    check_model("flh");
    bus.flush = 1'b0; bus.hold = 1'b0;

    // Hold for three cycles with a pending ID instruction.
    set_id(5'd1, 5'd2, 32'h10, 32'h20, 5'd10, 1'b1, 1'b0);
    tick();
    set_id(5'd3, 5'd4, 32'h30, 32'h40, 5'd11, 1'b1, 1'b0);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold.stall", 32'(bus.stall_id), 32'd1);
      tick();
      chk("hold.rd", 32'(bus.ex_rd), 32'd10);
      chk("hold.Ain", bus.Ain, 32'h10);
      check_model("hold");
    end
    bus.hold = 1'b0;
    tick();
    chk("rel.rd", 32'(bus.ex_rd), 32'd11);
    chk("rel.Ain", bus.Ain, 32'h30);
    idle();
    tick();
    chk("rel.nodup", 32'(bus.ex_valid), 32'd0);

    // Operand select: A=pc, B=imm.
    set_id(5'd1, 5'd2, 32'hAAA, 32'hBBB, 5'd12, 1'b1, 1'b0);
    bus.id_asel = ASEL_PC; bus.id_bsel = BSEL_IMM;
    bus.id_pc = 32'h100; bus.id_imm = 32'hFFFF_FFFC;
    tick();
    chk("sel.Ain", bus.Ain, 32'h100);
    chk("sel.Bin", bus.Bin, 32'hFFFF_FFFC);
    chk("sel.CA", bus.COMPAin, 32'hAAA);
    chk("sel.CB", bus.COMPBin, 32'hBBB);
    check_model("sel");

    // Random traffic with small register indices to provoke hazards and hits.
    for (int c = 0; c < 400; c++) begin
      rst_n            = ($urandom_range(49) != 0);
      bus.id_valid     = ($urandom_range(3) != 0);
      bus.id_rs1       = REG_AW'($urandom_range(7));
      bus.id_rs2       = REG_AW'($urandom_range(7));
      bus.id_rs1_data  = $urandom;
      bus.id_rs2_data  = $urandom;
      bus.id_imm       = $urandom;
      bus.id_pc        = $urandom;
      bus.id_asel      = 1'($urandom_range(1));
      bus.id_bsel      = 1'($urandom_range(1));
      bus.id_aluop     = 3'($urandom_range(7));
      bus.id_unsigned  = 1'($urandom_range(1));
      bus.id_rd        = REG_AW'($urandom_range(7));
      bus.id_regwrite  = 1'($urandom_range(1));
      bus.id_memread   = ($urandom_range(2) == 0);
      bus.mem_rd       = REG_AW'($urandom_range(7));
      bus.mem_regwrite = 1'($urandom_range(1));
      bus.mem_data     = $urandom;
      bus.wb_rd        = REG_AW'($urandom_range(7));
      bus.wb_regwrite  = 1'($urandom_range(1));
      bus.wb_data      = $urandom;
      bus.flush        = ($urandom_range(7) == 0);
      bus.hold         = ($urandom_range(5) == 0);
      #1;
      check_model("rnd.pre");
      tick();
      check_model("rnd.post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
